// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide unit controller.
// A mult or div result is computed at the start edge and held in pend_hi/pend_lo.
// It becomes architectural (hi/lo) after a fixed busy latency, so the pipeline sees
// the multi-cycle timing of an iterative unit.
// The operation can be aborted synchronously with clr, or asynchronously with reset.
// There is no valid/ready handshake: start is a one-cycle command that is accepted
// only in IDLE, and the unit drops it silently while busy.
module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_sel,
    input  logic        md_use_d,
    input  logic        clr,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out,
    output logic        dbg_state
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYC);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYC);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;      // low when the pending result must not reach HI/LO (div by zero)

    logic        is_mul, is_div, is_long;
    logic [63:0] mul_res;
    logic [31:0] quo, rem;

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_long = is_mul || is_div;

    // 32x32->64 product; signed form sign-extends both operands, unsigned zero-extends.
    always_comb begin
        if (op == OP_MULT)
            mul_res = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        else
            mul_res = {32'd0, src_a} * {32'd0, src_b};
    end

    // Quotient/remainder; the -1 divisor is handled apart so 0x80000000/-1 wraps to 0x80000000.
    always_comb begin
        quo = 32'd0;
        rem = 32'd0;
        if (src_b != 32'd0) begin
            if (op == OP_DIVU) begin
                quo = src_a / src_b;
                rem = src_a % src_b;
            end else if (src_b == 32'hFFFF_FFFF) begin
                quo = 32'd0 - src_a;
                rem = 32'd0;
            end else begin
                quo = $unsigned($signed(src_a) / $signed(src_b));
                rem = $unsigned($signed(src_a) % $signed(src_b));
            end
        end
    end

    // Next-state logic: clr wins over both launch and completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && is_long) state_next = RUN;
            RUN:  if (cnt == 4'd1)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath: operand capture, countdown, and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (clr) begin
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                if (is_mul) begin
                    pend_hi <= mul_res[63:32];
                    pend_lo <= mul_res[31:0];
                    pend_wr <= 1'b1;
                    cnt     <= MUL_CNT;
                end else if (is_div) begin
                    pend_hi <= rem;
                    pend_lo <= quo;
                    pend_wr <= (src_b != 32'd0);
                    cnt     <= DIV_CNT;
                end else if (op == OP_MTHI) begin
                    hi <= src_a;
                end else if (op == OP_MTLO) begin
                    lo <= src_a;
                end
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    // Status and read mux; reads see only committed HI/LO.
    assign busy      = (state == RUN);
    assign dbg_state = state;
    assign stall_req = md_use_d && (busy || (start && is_long));
    assign mdu_out   = rd_sel ? lo : hi;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: random and directed checks of mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;

    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NONE7 = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        rd_sel = 1'b0;
    logic        md_use_d = 1'b0;
    logic        clr = 1'b0;
    logic        busy, stall_req, dbg_state;
    logic [31:0] hi, lo, mdu_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;     // model architectural HI
    logic [31:0] m_lo = 32'd0;     // model architectural LO
    logic [63:0] exp_q[$];         // expected {hi,lo} per issued long op

    mdu_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_sel(rd_sel), .md_use_d(md_use_d), .clr(clr), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo), .mdu_out(mdu_out), .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference: new {hi,lo} after op completes, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return 64'(ua * ub);
            OP_DIV: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            OP_MTHI: return {a, cur[31:0]};
            OP_MTLO: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o == OP_MULT || o == OP_MULTU) return MUL_CYC;
        if (o == OP_DIV  || o == OP_DIVU)  return DIV_CYC;
        return 0;
    endfunction

    // Driver: present a one-cycle start; returns #1 after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
    endtask

    // Count cycles busy stays high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue an op, track the model, check latency and final HI/LO.
    task automatic run_and_check(input string name, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] e;
        exp_q.push_back(ref_result(o, a, b, {m_hi, m_lo}));
        issue(o, a, b);
        wait_idle(n);
        e = exp_q.pop_front();
        {m_hi, m_lo} = e;
        checks++;
        if (n != lat_of(o)) begin
            failures++;
            $display("FAIL %s busy_cycles op=%0d actual=%0d required=%0d", name, o, n, lat_of(o));
        end
        checks++;
        if (hi !== e[63:32] || lo !== e[31:0]) begin
            failures++;
            $display("FAIL %s hilo op=%0d a=%h b=%h actual=%h_%h required=%h_%h",
                     name, o, a, b, hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mdu_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_state actual busy=%b stall=%b hi=%h lo=%h out=%h required all zero",
                     busy, stall_req, hi, lo, mdu_out);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_and_check("mult_dir", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        run_and_check("multu_dir", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int i = 0; i < 6; i++)
            run_and_check("mult_rnd", ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU,
                          $urandom, $urandom);
    endtask

    task automatic test_div();
        run_and_check("div_dir", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        run_and_check("divu_zero", OP_DIVU, 32'h0000_0007, 32'h0000_0000);
        run_and_check("div_zero", OP_DIV, 32'h8000_0001, 32'h0000_0000);
        run_and_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            run_and_check("div_rnd", ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU,
                          $urandom, ($urandom_range(0, 1) == 0) ? $urandom_range(1, 50) : $urandom);
    endtask

    // stall_req over start cycle plus busy cycles; a second start during RUN must be dropped.
    task automatic test_stall();
        int run_len, n;
        logic [63:0] e;
        e = ref_result(OP_MULT, 32'h0000_1234, 32'hFFFF_FFFD, {m_hi, m_lo});
        md_use_d = 1'b1;
        start = 1'b1; op = OP_MULT; src_a = 32'h0000_1234; src_b = 32'hFFFF_FFFD;
        #1;
        run_len = (stall_req === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (stall_req === 1'b1) run_len++;
            if (n == 1) begin
                start = 1'b1; op = OP_MULT; src_a = $urandom; src_b = $urandom;
            end else if (n == 2) begin
                start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; op = OP_NONE;
            end
            #1;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; op = OP_NONE;
        #1;
        checks++;
        if (run_len != MUL_CYC + 1) begin
            failures++;
            $display("FAIL stall_len actual=%0d required=%0d", run_len, MUL_CYC + 1);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_after_busy actual=%b required=0", stall_req);
        end
        {m_hi, m_lo} = e;
        checks++;
        if (hi !== m_hi || lo !== m_lo || n != MUL_CYC) begin
            failures++;
            $display("FAIL start_in_run_ignored actual=%h_%h n=%0d required=%h_%h n=%0d",
                     hi, lo, n, m_hi, m_lo, MUL_CYC);
        end
        md_use_d = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_use actual=%b required=0", stall_req);
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi actual hi=%h busy=%b required hi=12345678 busy=0", hi, busy);
        end
        op = OP_MTLO; src_a = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
        checks++;
        if (lo !== m_lo || hi !== m_hi || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo actual hi=%h lo=%h busy=%b required %h %h 0", hi, lo, busy, m_hi, m_lo);
        end
        rd_sel = 1'b0; #1;
        checks++;
        if (mdu_out !== m_hi) begin
            failures++;
            $display("FAIL mdu_out_hi actual=%h required=%h", mdu_out, m_hi);
        end
        rd_sel = 1'b1; #1;
        checks++;
        if (mdu_out !== m_lo) begin
            failures++;
            $display("FAIL mdu_out_lo actual=%h required=%h", mdu_out, m_lo);
        end
        rd_sel = 1'b0;
    endtask

    task automatic test_none_ops();
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? OP_NONE : OP_NONE7, $urandom, $urandom);
            checks++;
            if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL none_op actual busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    // clr on busy cycle 4 of a div, and on the final cycle of a mult.
    task automatic test_clr();
        int n;
        issue(OP_DIV, 32'h0000_0064, 32'h0000_0007);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL clr_div actual busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        issue(OP_MULT, 32'h0000_0003, 32'h0000_0005);
        repeat (MUL_CYC - 1) @(posedge clk);
        #1;
        clr = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'h5555_AAAA;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0; op = OP_NONE;
        wait_idle(n);
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL clr_last actual busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    // Asynchronous reset between edges during RUN, then restart on the first edge.
    task automatic test_reset_mid_run();
        int n;
        run_and_check("pre_reset", OP_MULTU, $urandom, $urandom);
        issue(OP_DIVU, 32'hFFFF_0000, 32'h0000_0003);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run actual busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); reset = 1'b0;
        wait_idle(n);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || n != 0) begin
            failures++;
            $display("FAIL reset_no_update actual hi=%h lo=%h n=%0d required 0 0 0", hi, lo, n);
        end
        run_and_check("post_reset", OP_MULT, $urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(1, 6));
            run_and_check("b2b", o, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi_mtlo();
        test_none_ops();
        test_clr();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: MUL_CYC, 5, busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter: DIV_CYC, 10, busy cycles for div/divu (legal range 1..15).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-005 Port: start  input  1  E-stage MDU instruction valid this cycle; sampled at the rising edge.
REQ-006 Port: op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-007 Port: src_a  input  32  rs operand (already forwarded).
REQ-008 Port: src_b  input  32  rt operand (already forwarded).
REQ-009 Port: rd_sel  input  1  read select: 0 = HI, 1 = LO.
REQ-010 Port: md_use_d  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 Port: clr  input  1  synchronous abort of an in-flight operation.
REQ-012 Port: busy  output  1  multi-cycle operation in progress.
REQ-013 Port: stall_req  output  1  request to freeze F/D and bubble E.
REQ-014 Port: hi  output  32  architectural HI register.
REQ-015 Port: lo  output  32  architectural LO register.
REQ-016 Port: mdu_out  output  32  hi when rd_sel=0, else lo; combinational.

Function
REQ-017 States SHALL be IDLE and RUN; busy SHALL equal (state==RUN), registered.
REQ-018 In IDLE, start=1 with op mult/multu SHALL compute the 64-bit product at that edge into pend_hi/pend_lo, load cnt=MUL_CYC, and enter RUN.
REQ-019 In IDLE, start=1 with op div/divu SHALL latch pend_lo=quotient, pend_hi=remainder, load cnt=DIV_CYC, and enter RUN.
REQ-020 Signed multiply SHALL use two's-complement 32x32->64; unsigned SHALL zero-extend both operands.
REQ-021 Signed divide SHALL truncate toward zero; remainder SHALL take the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0.
REQ-022 Divide with src_b=0 (signed or unsigned) SHALL still run DIV_CYC busy cycles and SHALL leave HI/LO unchanged on completion.
REQ-023 In RUN, each edge SHALL decrement cnt; at the edge where cnt==1, HI/LO SHALL load pend_hi/pend_lo and state SHALL return to IDLE.
REQ-024 Hence busy SHALL be high for exactly MUL_CYC (or DIV_CYC) cycles after the start edge, and new HI/LO SHALL be visible the first cycle busy is low.
REQ-025 In IDLE, start=1 with mthi (mtlo) SHALL write src_a to HI (LO) at that edge; busy SHALL stay low.
REQ-026 start=1 while in RUN SHALL be ignored: no operand capture, no HI/LO write, cnt unaffected.
REQ-027 start=1 with op 000 or 111 SHALL have no effect.
REQ-028 clr=1 at an edge SHALL force IDLE, discard pend_hi/pend_lo, leave HI/LO unchanged, and take priority over completion and over start in the same cycle.
REQ-029 stall_req SHALL equal md_use_d AND (busy OR (start AND op in {mult, multu, div, divu})); combinational.
REQ-030 mdu_out SHALL reflect HI/LO as registered; no bypass of pending results.

Reset
REQ-031 On reset assertion: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pend_hi=pend_lo=0, immediately, without a clock edge.
REQ-032 Reset asserted during RUN SHALL abandon the operation; no HI/LO update on deassertion.
REQ-033 After reset release, the first rising edge SHALL accept start normally.

Verification
REQ-034 mult src_a=0xFFFFFFFF, src_b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 div src_a=0xFFFFFFF9 (-7), src_b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 7/0 -> busy 10 cycles, HI/LO unchanged.
REQ-036 mult issued, md_use_d=1 during start cycle and all busy cycles -> stall_req high 6 consecutive cycles, low on the first non-busy cycle; second start during RUN ignored.
REQ-037 mthi src_a=0x12345678 then mtlo src_a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge each, busy never asserted; mdu_out follows rd_sel.
REQ-038 div started, clr=1 on busy cycle 4 -> busy low next cycle, HI/LO retain prior values; repeat with reset pulse mid-RUN between edges -> hi=lo=0, busy=0 immediately.
